// File: rtl/imem_sync_loader_if.sv
// Load-port and fetch-port bundle for imem_sync_loader.
// master drives the byte stream and PC; slave is the memory/loader.
interface imem_sync_loader_if #(
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  // Byte-stream loader side
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_ovf;
  logic [AW:0]   ld_words;

  // Instruction fetch side
  logic [31:0]   fetch_pc;
  logic          fetch_en;
  logic          flush;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          fault;

  modport master (
    output ld_start, ld_valid, ld_byte, ld_last, fetch_pc, fetch_en, flush,
    input  ld_ready, ld_done, ld_ovf, ld_words, instr_out, instr_valid, fault
  );

  modport slave (
    input  ld_start, ld_valid, ld_byte, ld_last, fetch_pc, fetch_en, flush,
    output ld_ready, ld_done, ld_ovf, ld_words, instr_out, instr_valid, fault
  );
endinterface

// File: rtl/imem_sync_loader.sv
// Instruction memory with a byte-stream loader and a registered fetch port.
// RUN serves fetches; LOAD accepts little-endian bytes and writes words from index 0.
module imem_sync_loader #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst_n,
  imem_sync_loader_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {StRun, StLoad} state_e;

  state_e      state_q, state_d;
  logic [AW:0] words_q, words_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [31:0] instr_q, instr_d;
  logic        ivalid_q, ivalid_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic        accept, full, word_end, fetch_bad;
  logic [31:0] word_asm;

  // Byte assembly: current byte placed in its lane, lanes above it zero-filled
  always_comb begin
    accept   = (state_q == StLoad) && bus.ld_valid && !bus.ld_start;
    full     = (words_q == (AW+1)'(DEPTH));
    word_end = (lane_q == 2'd3) || bus.ld_last;
    unique case (lane_q)
      2'd0:    word_asm = {24'h0, bus.ld_byte};
      2'd1:    word_asm = {16'h0, bus.ld_byte, acc_q[7:0]};
      2'd2:    word_asm = {8'h0, bus.ld_byte, acc_q[15:0]};
      default: word_asm = {bus.ld_byte, acc_q};
    endcase
  end

  // Loader FSM next state and memory write strobe
  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = words_q[AW-1:0];
    mem_wdata = word_asm;
    if (bus.ld_start) begin
      // Start wins over a coincident byte, which is dropped
      state_d = StLoad;
      words_d = '0;
      lane_d  = 2'd0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (full) ovf_d = 1'b1;
      if (word_end) begin
        lane_d = 2'd0;
        acc_d  = '0;
        // Once full, words are discarded rather than wrapping onto index 0
        if (!full) begin
          mem_we  = 1'b1;
          words_d = words_q + (AW+1)'(1);
        end
      end else begin
        lane_d = lane_q + 2'd1;
        acc_d  = word_asm[23:0];
      end
      if (bus.ld_last) begin
        state_d = StRun;
        done_d  = 1'b1;
      end
    end
  end

  // Fetch register next state: load/flush squash, fetch_en=0 holds
  always_comb begin
    instr_d   = instr_q;
    ivalid_d  = ivalid_q;
    fault_d   = fault_q;
    fetch_bad = (bus.fetch_pc[1:0] != 2'b00) || ((bus.fetch_pc >> (AW + 2)) != 32'd0);
    if ((state_q == StLoad) || bus.flush) begin
      instr_d  = NOP_WORD;
      ivalid_d = 1'b0;
      fault_d  = 1'b0;
    end else if (bus.fetch_en) begin
      if (fetch_bad) begin
        instr_d  = NOP_WORD;
        ivalid_d = 1'b0;
        fault_d  = 1'b1;
      end else begin
        instr_d  = mem[bus.fetch_pc[AW+1:2]];
        ivalid_d = 1'b1;
        fault_d  = 1'b0;
      end
    end
  end

  // Control and fetch state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      words_q  <= '0;
      lane_q   <= 2'd0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      instr_q  <= NOP_WORD;
      ivalid_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      words_q  <= words_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      fault_q  <= fault_d;
    end
  end

  // Storage array: never reset, so contents survive reset and restarts
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.ld_ready    = (state_q == StLoad);
  assign bus.ld_done     = done_q;
  assign bus.ld_ovf      = ovf_q;
  assign bus.ld_words    = words_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = ivalid_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_imem_sync_loader.sv
// Randomized bench for imem_sync_loader against a byte-list memory model.
module tb_imem_sync_loader;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_sync_loader_if #(.DEPTH(DEPTH)) bus ();

  imem_sync_loader #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_known [DEPTH];
  int unsigned last_words = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_byte = 8'h00; bus.ld_last = 1'b0;
    bus.fetch_pc = 32'h0; bus.fetch_en = 1'b0; bus.flush = 1'b0;
  endtask

  // Memory image implied by a byte stream: word w = bytes 4w..4w+3, little-endian.
  // Without completion only whole words reach memory.
  function automatic void model_load(input logic [7:0] q[$], input bit complete,
                                     output int unsigned words, output bit ovf);
    int n  = q.size();
    int nw = complete ? (n + 3) / 4 : n / 4;
    ovf   = (n > 4 * DEPTH);
    words = (nw > DEPTH) ? DEPTH : nw;
    for (int w = 0; w < int'(words); w++) begin
      logic [31:0] v = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v = v | (32'(q[4*w+k]) << (8 * k));
      model_mem[w]   = v;
      model_known[w] = 1'b1;
    end
  endfunction

  task automatic start_load();
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'($urandom_range(0, 1));
    bus.ld_byte  = 8'($urandom);
    bus.ld_last  = 1'($urandom_range(0, 1));
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0;
    step();
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.ld_words !== '0 || bus.ld_ovf !== 1'b0) begin
      failures++;
      $display("FAIL start_load: ready=%b words=%0d ovf=%b, required ready=1 words=0 ovf=0",
               bus.ld_ready, bus.ld_words, bus.ld_ovf);
    end
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit with_last, input int max_gap);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'($urandom);
        bus.fetch_pc = 32'($urandom_range(0, DEPTH * 4 - 1));
        bus.fetch_en = 1'($urandom_range(0, 1));
        step();
      end
      bus.ld_valid = 1'b1;
      bus.ld_byte  = q[i];
      bus.ld_last  = with_last && (i == q.size() - 1);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic drive_load(input logic [7:0] q[$], input int max_gap);
    int unsigned w;
    bit          o;
    start_load();
    send_bytes(q, 1'b1, max_gap);
    model_load(q, 1'b1, w, o);
    last_words = w;
    checks++;
    if (bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_done: done=%b ready=%b, required done=1 ready=0",
               bus.ld_done, bus.ld_ready);
    end
    checks++;
    if (bus.ld_words !== (AW+1)'(w) || bus.ld_ovf !== o) begin
      failures++;
      $display("FAIL load_count: words=%0d ovf=%b, required words=%0d ovf=%b",
               bus.ld_words, bus.ld_ovf, w, o);
    end
    checks++;
    if (bus.instr_out !== NOP || bus.instr_valid !== 1'b0 || bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL load_fetch_squash: instr=%h valid=%b fault=%b, required %h/0/0",
               bus.instr_out, bus.instr_valid, bus.fault, NOP);
    end
    bus.fetch_en = 1'b0;
    step();
    checks++;
    if (bus.ld_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b, required 0", bus.ld_done);
    end
  endtask

  // Fetch one PC and compare against the model's view of that address
  task automatic fetch_check(input logic [31:0] pc, input string name);
    bit bad = (pc % 4 != 0) || (pc >= DEPTH * 4);
    int idx = int'(pc / 4);
    bus.fetch_pc = pc; bus.fetch_en = 1'b1; bus.flush = 1'b0;
    step();
    bus.fetch_en = 1'b0;
    if (bad) begin
      checks++;
      if (bus.instr_out !== NOP || bus.instr_valid !== 1'b0 || bus.fault !== 1'b1) begin
        failures++;
        $display("FAIL %s pc=%h: instr=%h valid=%b fault=%b, required %h/0/1",
                 name, pc, bus.instr_out, bus.instr_valid, bus.fault, NOP);
      end
    end else begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.fault !== 1'b0 ||
          (model_known[idx] && bus.instr_out !== model_mem[idx])) begin
        failures++;
        $display("FAIL %s pc=%h: instr=%h valid=%b fault=%b, required %h/1/0",
                 name, pc, bus.instr_out, bus.instr_valid, bus.fault, model_mem[idx]);
      end
    end
  endtask

  task automatic verify_mem(input string name);
    for (int i = 0; i < DEPTH; i++)
      if (model_known[i]) fetch_check(32'(4 * i), name);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0 || bus.ld_ovf !== 1'b0 ||
        bus.ld_words !== '0 || bus.instr_out !== NOP || bus.instr_valid !== 1'b0 ||
        bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b done=%b ovf=%b words=%0d instr=%h valid=%b fault=%b",
               bus.ld_ready, bus.ld_done, bus.ld_ovf, bus.ld_words, bus.instr_out,
               bus.instr_valid, bus.fault);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed_load();
    logic [7:0] q[$] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h07, 8'hF7, 8'h00};
    drive_load(q, 0);
    fetch_check(32'd0, "directed_w0");
    checks++;
    if (bus.instr_out !== 32'h0050_0013) begin
      failures++;
      $display("FAIL directed_w0_const: instr=%h, required 00500013", bus.instr_out);
    end
  endtask

  task automatic test_fetch_hold();
    bus.fetch_pc = 32'd4; bus.fetch_en = 1'b1;
    step();
    checks++;
    if (bus.instr_out !== 32'h00F7_07B3 || bus.instr_valid !== 1'b1 || bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pc4: instr=%h valid=%b fault=%b, required 00f707b3/1/0",
               bus.instr_out, bus.instr_valid, bus.fault);
    end
    bus.fetch_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.fetch_pc = $urandom;
      step();
      checks++;
      if (bus.instr_out !== 32'h00F7_07B3 || bus.instr_valid !== 1'b1 || bus.fault !== 1'b0) begin
        failures++;
        $display("FAIL fetch_hold: instr=%h valid=%b fault=%b, required 00f707b3/1/0",
                 bus.instr_out, bus.instr_valid, bus.fault);
      end
    end
  endtask

  task automatic test_faults();
    fetch_check(32'd2, "fault_misalign");
    fetch_check(32'(DEPTH * 4), "fault_range");
    fetch_check(32'h8000_0000 | (32'($urandom) & 32'hFFFC), "fault_high");
    bus.fetch_pc = 32'd0;
    step();
    checks++;
    if (bus.fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_hold: fault=%b, required 1", bus.fault);
    end
    bus.fetch_pc = 32'd2; bus.fetch_en = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.fetch_en = 1'b0;
    checks++;
    if (bus.instr_out !== NOP || bus.instr_valid !== 1'b0 || bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL flush: instr=%h valid=%b fault=%b, required %h/0/0",
               bus.instr_out, bus.instr_valid, bus.fault, NOP);
    end
    fetch_check(32'd0, "after_flush");
  endtask

  task automatic test_run_ignores_bytes();
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_byte = 8'($urandom); bus.ld_last = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0 || bus.ld_words !== (AW+1)'(last_words)) begin
        failures++;
        $display("FAIL run_ignore: ready=%b done=%b words=%0d, required 0/0/%0d",
                 bus.ld_ready, bus.ld_done, bus.ld_words, last_words);
      end
    end
    idle_inputs();
    verify_mem("run_ignore_mem");
  endtask

  task automatic test_partial();
    logic [7:0] q[$];
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    drive_load(q, 1);
    fetch_check(32'd4, "partial_w1");
    checks++;
    if (bus.instr_out !== {24'h0, q[4]}) begin
      failures++;
      $display("FAIL partial_zero_fill: instr=%h, required %h", bus.instr_out, {24'h0, q[4]});
    end
  endtask

  task automatic test_restart();
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int unsigned w;
    bit          o;
    for (int i = 0; i < 6; i++) q1.push_back(8'($urandom));
    for (int i = 0; i < 11; i++) q2.push_back(8'($urandom));
    start_load();
    send_bytes(q1, 1'b0, 1);
    model_load(q1, 1'b0, w, o);
    checks++;
    if (bus.ld_words !== (AW+1)'(1) || bus.ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre: words=%0d ready=%b, required 1/1", bus.ld_words, bus.ld_ready);
    end
    drive_load(q2, 1);
    verify_mem("restart_mem");
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    for (int i = 0; i < DEPTH * 4 + 1; i++) q.push_back(8'($urandom));
    drive_load(q, 0);
    verify_mem("overflow_mem");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] q[$];
      int n = $urandom_range(1, DEPTH * 4);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      drive_load(q, 2);
      for (int f = 0; f < 12; f++) begin
        logic [31:0] pc = 32'($urandom_range(0, DEPTH * 4 + 7));
        if ($urandom_range(0, 3) != 0) pc = pc & 32'hFFFF_FFFC;
        fetch_check(pc, "random_fetch");
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] q[$];
    int unsigned w;
    bit          o;
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    start_load();
    send_bytes(q, 1'b0, 0);
    model_load(q, 1'b0, w, o);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.ld_words !== '0 || bus.instr_out !== NOP ||
        bus.instr_valid !== 1'b0 || bus.fault !== 1'b0 || bus.ld_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load: ready=%b words=%0d instr=%h valid=%b fault=%b ovf=%b",
               bus.ld_ready, bus.ld_words, bus.instr_out, bus.instr_valid, bus.fault, bus.ld_ovf);
    end
    step();
    rst_n = 1'b1;
    step();
    verify_mem("reset_mid_load_mem");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
    test_reset();
    test_directed_load();
    test_fetch_hold();
    test_faults();
    test_run_ignores_bytes();
    test_partial();
    test_restart();
    test_overflow();
    test_random();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
